// File: rtl/tetris_move_arbiter.sv
// Move arbiter: turns button levels, frame ticks and gravity into one
// command at a time for the playfield engine over a valid/ready port.
module tetris_move_arbiter #(
    parameter int unsigned DAS_DELAY      = 16,
    parameter int unsigned ARR_PERIOD     = 4,
    parameter int unsigned GRAVITY_PERIOD = 48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       game_run,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_down,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [2:0] move_cmd
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned N_REP = 3;   // repeating buttons: left, right, down
    localparam int unsigned N_CMD = 5;   // pending bit c holds command code c+1

    localparam logic [CNT_W-1:0] DAS_8     = CNT_W'(DAS_DELAY);
    localparam logic [CNT_W-1:0] ARR_8     = CNT_W'(ARR_PERIOD);
    localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAVITY_PERIOD - 1);

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_LEFT  = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd2;
    localparam logic [2:0] CMD_ROT   = 3'd3;
    localparam logic [2:0] CMD_DOWN  = 3'd4;
    localparam logic [2:0] CMD_GRAV  = 3'd5;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [3:0]                   w_btn;        // {down, rot, right, left}
    logic [3:0]                   r_prev;
    logic [3:0]                   w_edge;
    logic                         w_conflict;
    logic [N_REP-1:0]             w_rep_btn;
    logic [N_REP-1:0]             w_rep_frz;
    logic [N_REP-1:0][CNT_W-1:0]  r_hold;
    logic [N_REP-1:0][CNT_W-1:0]  r_rep;
    logic [N_REP-1:0][CNT_W-1:0]  w_hold_nxt;
    logic [N_REP-1:0][CNT_W-1:0]  w_rep_nxt;
    logic [N_REP-1:0]             w_rep_fire;
    logic [CNT_W-1:0]             r_grav;
    logic [CNT_W-1:0]             w_grav_nxt;
    logic                         w_grav_fire;
    logic [N_CMD-1:0]             r_pend;
    logic [N_CMD-1:0]             w_evt;
    logic [N_CMD-1:0]             w_clr;
    logic [N_CMD-1:0]             w_pend_nxt;
    logic                         w_grant;
    logic [2:0]                   w_sel_cmd;
    logic [0:0]                   r_state;
    logic [0:0]                   w_state_nxt;
    logic                         w_valid_nxt;
    logic [2:0]                   w_cmd_nxt;

    assign w_btn      = {btn_down, btn_rot, btn_right, btn_left};
    assign w_edge     = w_btn & ~r_prev;
    assign w_conflict = btn_left & btn_right;
    assign w_rep_btn  = {btn_down, btn_right, btn_left};
    assign w_rep_frz  = {1'b0, w_conflict, w_conflict};

    // Button history for press-edge detection; tracks even while paused
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_prev <= '0;
        else       r_prev <= w_btn;
    end

    // DAS hold and ARR repeat counters per repeating button
    always_comb begin
        w_hold_nxt = r_hold;
        w_rep_nxt  = r_rep;
        w_rep_fire = '0;
        for (int i = 0; i < N_REP; i++) begin
            if (!w_rep_btn[i]) begin
                w_hold_nxt[i] = '0;
                w_rep_nxt[i]  = '0;
            end else if (tick_in && !w_rep_frz[i]) begin
                if (r_hold[i] != DAS_8) begin
                    w_hold_nxt[i] = r_hold[i] + CNT_W'(1);
                    w_rep_fire[i] = (w_hold_nxt[i] == DAS_8);
                end else begin
                    w_rep_nxt[i] = r_rep[i] + CNT_W'(1);
                    if (w_rep_nxt[i] == ARR_8) begin
                        w_rep_fire[i] = 1'b1;
                        w_rep_nxt[i]  = '0;
                    end
                end
            end
        end
    end

    assign w_grav_fire = tick_in & (r_grav == GRAV_LAST);

    // Gravity counter; a granted soft drop restarts the gravity period
    always_comb begin
        w_grav_nxt = r_grav;
        if (tick_in) w_grav_nxt = w_grav_fire ? '0 : r_grav + CNT_W'(1);
        if (w_clr[3]) w_grav_nxt = '0;
    end

    // Counter registers, all cleared while the game is not running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
            r_rep  <= '0;
            r_grav <= '0;
        end else if (!game_run) begin
            r_hold <= '0;
            r_rep  <= '0;
            r_grav <= '0;
        end else begin
            r_hold <= w_hold_nxt;
            r_rep  <= w_rep_nxt;
            r_grav <= w_grav_nxt;
        end
    end

    assign w_evt[0] = (w_edge[0] | w_rep_fire[0]) & ~w_conflict;
    assign w_evt[1] = (w_edge[1] | w_rep_fire[1]) & ~w_conflict;
    assign w_evt[2] = w_edge[2];
    assign w_evt[3] = w_edge[3] | w_rep_fire[2];
    assign w_evt[4] = w_grav_fire;

    assign w_grant = (r_state == ST_OFFER) & move_ready;

    // Clear only the flag of the command being granted
    always_comb begin
        w_clr = '0;
        for (int c = 0; c < N_CMD; c++) begin
            w_clr[c] = w_grant && (move_cmd == 3'(c + 1));
        end
    end

    // New events win over a same-cycle grant clear
    assign w_pend_nxt = (r_pend & ~w_clr) | w_evt;

    // Pending flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_pend <= '0;
        else if (!game_run) r_pend <= '0;
        else                r_pend <= w_pend_nxt;
    end

    // Fixed priority: GRAV, ROT, LEFT, RIGHT, DOWN
    always_comb begin
        w_sel_cmd = CMD_NONE;
        if      (r_pend[4]) w_sel_cmd = CMD_GRAV;
        else if (r_pend[2]) w_sel_cmd = CMD_ROT;
        else if (r_pend[0]) w_sel_cmd = CMD_LEFT;
        else if (r_pend[1]) w_sel_cmd = CMD_RIGHT;
        else if (r_pend[3]) w_sel_cmd = CMD_DOWN;
    end

    // Offer FSM next state and registered outputs
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = move_valid;
        w_cmd_nxt   = move_cmd;
        case (r_state)
            ST_IDLE: begin
                if (|r_pend) begin
                    w_state_nxt = ST_OFFER;
                    w_valid_nxt = 1'b1;
                    w_cmd_nxt   = w_sel_cmd;
                end
            end
            ST_OFFER: begin
                if (move_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                    w_cmd_nxt   = CMD_NONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_cmd_nxt   = CMD_NONE;
            end
        endcase
        if (!game_run) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
            w_cmd_nxt   = CMD_NONE;
        end
    end

    // Offer FSM state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            move_valid <= 1'b0;
            move_cmd   <= CMD_NONE;
        end else begin
            r_state    <= w_state_nxt;
            move_valid <= w_valid_nxt;
            move_cmd   <= w_cmd_nxt;
        end
    end

endmodule

// File: tb/tb_tetris_move_arbiter.sv
// Bench for tetris_move_arbiter: vector table, directed sequences and a
// random run compared every cycle against a tick-counting reference model.
module tb_tetris_move_arbiter;

    localparam int DAS = 16;
    localparam int ARR = 4;
    localparam int GP  = 48;

    logic       clk = 1'b0;
    logic       reset, tick_in, game_run;
    logic       btn_left, btn_right, btn_rot, btn_down, move_ready;
    logic       move_valid;
    logic [2:0] move_cmd;

    always #5 clk = ~clk;

    tetris_move_arbiter #(
        .DAS_DELAY(DAS), .ARR_PERIOD(ARR), .GRAVITY_PERIOD(GP)
    ) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .game_run(game_run),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot),
        .btn_down(btn_down), .move_ready(move_ready),
        .move_valid(move_valid), .move_cmd(move_cmd)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tick_n  = 0;
    int g_cmd[$];
    int g_tick[$];
    int exp_q[$];

    // Reference model: ticks held since press, ticks since last gravity restart
    bit [3:0] m_prev;   // {down, rot, right, left}
    int       m_held[3];
    int       m_grav;
    bit [5:0] m_pend;   // indexed by command code
    bit       m_valid;
    int       m_cmd;

    typedef struct {
        bit         rot;
        bit         rdy;
        bit         ev;
        logic [2:0] ec;
    } vec_t;
    vec_t tv[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit [5:0] ev;
        bit       grant, conflict, found;
        int       gcmd;
        bit       b[3];
        bit       pb[3];
        int       cm[3];
        int       prio[5];
        prio = '{5, 3, 1, 2, 4};
        b    = '{btn_left, btn_right, btn_down};
        pb   = '{m_prev[0], m_prev[1], m_prev[3]};
        cm   = '{1, 2, 4};
        if (!game_run) begin
            m_pend = '0; m_held = '{0, 0, 0}; m_grav = 0; m_valid = 0; m_cmd = 0;
        end else begin
            ev       = '0;
            grant    = m_valid && move_ready;
            gcmd     = m_cmd;
            conflict = btn_left && btn_right;
            ev[3]    = btn_rot && !m_prev[2];
            for (int i = 0; i < 3; i++) begin
                if (!b[i]) m_held[i] = 0;
                else if (!(i < 2 && conflict)) begin
                    if (!pb[i]) ev[cm[i]] = 1'b1;
                    if (tick_in) begin
                        m_held[i]++;
                        if (m_held[i] >= DAS && (m_held[i] - DAS) % ARR == 0) ev[cm[i]] = 1'b1;
                    end
                end
            end
            if (tick_in) begin
                m_grav++;
                if (m_grav == GP) begin ev[5] = 1'b1; m_grav = 0; end
            end
            if (grant && gcmd == 4) m_grav = 0;
            if (m_valid) begin
                if (move_ready) begin m_valid = 0; m_cmd = 0; end
            end else begin
                found = 0;
                foreach (prio[k]) if (!found && m_pend[prio[k]]) begin
                    found = 1; m_valid = 1; m_cmd = prio[k];
                end
            end
            for (int c = 1; c <= 5; c++) m_pend[c] = (m_pend[c] && !(grant && gcmd == c)) || ev[c];
        end
        m_prev = {btn_down, btn_rot, btn_right, btn_left};
    endtask

    // One clock: log a grant, advance the model, compare after the edge
    task automatic step();
        if (move_valid === 1'b1 && move_ready) begin
            g_cmd.push_back(int'(move_cmd));
            g_tick.push_back(tick_n - 1);
        end
        model_step();
        if (tick_in) tick_n++;
        @(posedge clk);
        #1;
        check("model", {move_valid, move_cmd}, {m_valid, 3'(m_cmd)});
    endtask

    task automatic idle(input int n);
        tick_in = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_tick();
        tick_in = 1'b1;
        step();
        idle(5);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick_in = 0; game_run = 0; move_ready = 0;
        btn_left = 0; btn_right = 0; btn_rot = 0; btn_down = 0;
        m_prev = '0; m_held = '{0, 0, 0}; m_grav = 0; m_pend = '0; m_valid = 0; m_cmd = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", move_valid, 0);
        check("reset_cmd", move_cmd, 0);
        reset = 1'b0;
        tick_n = 0;
        g_cmd.delete();
        g_tick.delete();
    endtask

    function automatic int count_cmd(input int c);
        int n = 0;
        foreach (g_cmd[k]) if (g_cmd[k] == c) n++;
        return n;
    endfunction

    // Compare the tick indices of grants of command c against exp_q
    task automatic check_ticks(input string name, input int c);
        int got[$];
        foreach (g_cmd[k]) if (g_cmd[k] == c) got.push_back(g_tick[k]);
        check({name, "_count"}, got.size(), exp_q.size());
        foreach (exp_q[k]) check($sformatf("%s_%0d", name, k), (k < got.size()) ? got[k] : -1, exp_q[k]);
    endtask

    initial begin
        int base;
        int nv;

        // Single press: rotate held 3 clk, ready tied high
        tv[0] = '{0, 1, 0, 3'd0};
        tv[1] = '{1, 1, 0, 3'd0};
        tv[2] = '{1, 1, 1, 3'd3};
        tv[3] = '{1, 1, 0, 3'd0};
        for (int i = 4; i < 8; i++) tv[i] = '{0, 1, 0, 3'd0};
        do_reset();
        game_run = 1; move_ready = 1;
        idle(2);
        for (int i = 0; i < 8; i++) begin
            btn_rot = tv[i].rot; move_ready = tv[i].rdy;
            step();
            check($sformatf("press_valid_%0d", i), move_valid, tv[i].ev);
            check($sformatf("press_cmd_%0d", i), move_cmd, tv[i].ec);
        end
        idle(10);
        check("press_grants", g_cmd.size(), 1);
        check("press_grant_cmd", (g_cmd.size() > 0) ? g_cmd[0] : -1, 3);

        // Auto-repeat: right held for 30 ticks after tick 0
        do_reset();
        game_run = 1; move_ready = 1;
        idle(2);
        do_tick();
        btn_right = 1;
        idle(3);
        repeat (30) do_tick();
        btn_right = 0;
        idle(3);
        exp_q = '{0, 16, 20, 24, 28};
        check_ticks("repeat_right", 2);
        check("repeat_total", g_cmd.size(), 5);

        // Priority and hold: GRAV and LEFT pending with ready low
        do_reset();
        game_run = 1; move_ready = 0;
        idle(2);
        repeat (47) do_tick();
        btn_left = 1; tick_in = 1;
        step();
        tick_in = 0;
        step();
        check("prio_first_valid", move_valid, 1);
        check("prio_first_cmd", move_cmd, 5);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("prio_hold_%0d", i), {move_valid, move_cmd}, {1'b1, 3'd5});
        end
        move_ready = 1;
        step();
        check("prio_grant_drop", move_valid, 0);
        step();
        check("prio_next_valid", move_valid, 1);
        check("prio_next_cmd", move_cmd, 1);
        step();
        btn_left = 0;
        idle(5);
        check("prio_order_n", g_cmd.size(), 2);
        check("prio_order_0", (g_cmd.size() > 0) ? g_cmd[0] : -1, 5);
        check("prio_order_1", (g_cmd.size() > 1) ? g_cmd[1] : -1, 1);

        // Left/right conflict freezes right's hold count
        do_reset();
        game_run = 1; move_ready = 1;
        idle(2);
        btn_right = 1;
        idle(3);
        repeat (10) do_tick();
        check("conf_pre_right", count_cmd(2), 1);
        btn_left = 1;
        idle(3);
        g_cmd.delete(); g_tick.delete();
        repeat (40) do_tick();
        check("conf_left", count_cmd(1), 0);
        check("conf_right", count_cmd(2), 0);
        g_cmd.delete(); g_tick.delete();
        btn_left = 0;
        base = tick_n;
        repeat (10) do_tick();
        exp_q = '{base + 5, base + 9};
        check_ticks("conf_resume", 2);
        check("conf_post_left", count_cmd(1), 0);
        btn_right = 0;
        idle(3);

        // Gravity period and soft-drop restart
        do_reset();
        game_run = 1; move_ready = 1;
        idle(2);
        repeat (121) do_tick();
        btn_down = 1;
        idle(4);
        btn_down = 0;
        repeat (50) do_tick();
        exp_q = '{47, 95, 168};
        check_ticks("grav", 5);
        exp_q = '{120};
        check_ticks("soft", 4);

        // Abort mid-offer
        do_reset();
        game_run = 1; move_ready = 0;
        idle(2);
        btn_rot = 1; btn_left = 1;
        idle(3);
        check("abort_pre", {move_valid, move_cmd}, {1'b1, 3'd3});
        game_run = 0;
        step();
        check("abort_drop", {move_valid, move_cmd}, {1'b0, 3'd0});
        step();
        game_run = 1; move_ready = 1;
        nv = 0;
        repeat (10) begin
            step();
            if (move_valid !== 1'b0) nv++;
        end
        check("abort_quiet", nv, 0);
        check("abort_log", g_cmd.size(), 0);
        btn_rot = 0;
        step();
        btn_rot = 1;
        step();
        step();
        check("abort_new", {move_valid, move_cmd}, {1'b1, 3'd3});
        step();
        btn_rot = 0; btn_left = 0;
        idle(3);

        // Random run against the model
        do_reset();
        game_run = 1;
        for (int i = 0; i < 3000; i++) begin
            tick_in = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 79) == 0) btn_left  = ~btn_left;
            if ($urandom_range(0, 79) == 0) btn_right = ~btn_right;
            if ($urandom_range(0, 79) == 0) btn_rot   = ~btn_rot;
            if ($urandom_range(0, 79) == 0) btn_down  = ~btn_down;
            move_ready = 1'($urandom_range(0, 1));
            if (game_run && $urandom_range(0, 299) == 0) game_run = 0;
            else if (!game_run && $urandom_range(0, 3) == 0) game_run = 1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tetris_move_arbiter.md
# tetris_move_arbiter

Sequences all piece-motion requests into the single move port of the playfield engine. It takes debounced button levels (left, right, rotate, soft-down) and a frame tick, and generates press and auto-repeat (DAS/ARR) events plus periodic gravity drops. It arbitrates these events by fixed priority and hands one command at a time to the engine over a valid/ready handshake. It sits between the per-button debounce blocks and the game-logic core.

## Interface
- DAS_DELAY, 16: frame ticks a left/right/down button must be held before auto-repeat starts; legal range 1..255.
- ARR_PERIOD, 4: frame ticks between auto-repeat events; legal range 1..255.
- GRAVITY_PERIOD, 48: frame ticks between gravity drops; legal range 1..255.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick_in  in  1  one-clk frame strobe.
- game_run  in  1  level; 0 = paused or game over.
- btn_left, btn_right, btn_rot, btn_down  in  1 each  debounced button levels, synchronous to clk.
- move_ready  in  1  engine accepts the offered command this cycle.
- move_valid  out  1  a command is offered.
- move_cmd  out  3  command code: 0 NONE, 1 LEFT, 2 RIGHT, 3 ROT, 4 SOFT_DOWN, 5 GRAVITY.

## Operation
- **Press edge detection:** a registered copy of each button is kept. A press edge is `btn & ~prev`, evaluated every clk.
- **Pending flags:** there is one pending flag each for LEFT, RIGHT, ROT, DOWN and GRAV.
  - An event sets the flag. Repeated events while the flag is already set merge; they are not counted.
  - The flag clears when its command is granted. If a new event for the same command arrives in the grant cycle, the set wins and the flag stays 1.
- **Auto-repeat (left, right, down):**
  - An 8-bit hold counter increments on tick_in while the button is high, saturating at DAS_DELAY.
  - When the hold counter reaches DAS_DELAY, a repeat event fires. After that, an 8-bit repeat counter fires one event every ARR_PERIOD ticks.
  - Releasing the button zeroes both counters.
  - Rotate is press-edge only and never repeats.
- **Left/right conflict:** while btn_left and btn_right are both high, neither direction generates edge or repeat events. Both hold counters freeze.
- **Gravity:**
  - An 8-bit counter increments on tick_in. When it reaches GRAVITY_PERIOD-1 on a tick, it wraps to 0 and sets GRAV.
  - Granting SOFT_DOWN zeroes the gravity counter.
- **Priority (highest first):** GRAV, ROT, LEFT, RIGHT, DOWN.
- **FSM:**
  - IDLE: if game_run and any flag is set, latch the highest-priority command into move_cmd, set move_valid, go to OFFER.
  - OFFER: move_cmd and move_valid are held stable until move_ready=1. In that cycle the matching flag is cleared; move_valid drops on the next edge, move_cmd returns to 0, and the FSM goes to IDLE.
  - Flags set while in OFFER do not change the offered command.
- **game_run=0:** synchronously clears all flags and all counters, forces IDLE, move_valid=0 and move_cmd=0, including an abort mid-OFFER. Press-edge registers keep tracking the buttons, so a button already held when game_run rises does not produce an edge.

## Timing
- **Reset:** move_valid=0, move_cmd=0, all flags, counters and prev registers 0, FSM=IDLE.
- **Press latency:** the first edge sampling the button high sets the flag. move_valid is visible after the next edge. That is 2 clk, provided the FSM is idle and no higher-priority flag is set.
- **Grant spacing:** at least one IDLE cycle separates grants, so peak throughput is one command per 2 clk. With move_ready tied high, each offer lasts exactly 1 clk.
- **Repeat schedule:** for a button held from tick 0, events occur at the press, at tick DAS_DELAY, then at DAS_DELAY + k·ARR_PERIOD.
- **Counters:** all arithmetic is unsigned 8-bit. Equality compares use parameter values truncated to 8 bits. Parameters outside the legal range are unsupported.
- **Simultaneous gravity tick and SOFT_DOWN grant:** the counter is zeroed and GRAV is still set.

## Test plan
- **Single press:** reset, game_run=1, btn_rot pulsed high for 3 clk, move_ready=1 -> exactly one grant, move_cmd=3, move_valid high 1 clk, 2 clk after the press edge; no further grants.
- **Auto-repeat:** btn_right held for 30 ticks with DAS=16, ARR=4 -> RIGHT grants at the press and at ticks 16, 20, 24, 28; 5 total.
- **Priority and hold:** move_ready=0, GRAV and LEFT both pending -> move_cmd=5 is held stable for 10 clk. move_ready=1 -> GRAV is granted, then LEFT is offered 2 clk later.
- **Conflict:** btn_left and btn_right both held for 40 ticks -> no LEFT or RIGHT grant. Release btn_left -> RIGHT counters resume from their frozen values.
- **Gravity and soft drop:** no buttons for 96 ticks -> GRAV grants at ticks 47 and 95. Press btn_down at tick 120 -> the next GRAV is at tick 120+48.
- **Abort:** game_run dropped during OFFER -> move_valid=0 on the next edge, all flags clear, no grant after game_run returns until a new event occurs.
